// File: rtl/bipolar_plane_sequencer_if.sv
// Handshake/bus bundle for bipolar_plane_sequencer.
// Ports:
//   in_valid/in_ready/in_data             : activation vector from the buffer
//   plane_valid/plane_ready               : per-plane handshake to the array
//   wl_p/wl_n/plane_idx/plane_last        : current bit-plane payload
//   busy/skip_pulse                       : status
// master = sequencer side, slave = activation buffer / array side.
interface bipolar_plane_sequencer_if #(
  parameter int inBits   = 4,
  parameter int numLanes = 1
);
  localparam int outBits = inBits - 1;
  localparam int idxBits = (outBits > 1) ? $clog2(outBits) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [numLanes*inBits-1:0]   in_data;
  logic                         plane_valid;
  logic                         plane_ready;
  logic [numLanes-1:0]          wl_p;
  logic [numLanes-1:0]          wl_n;
  logic [idxBits-1:0]           plane_idx;
  logic                         plane_last;
  logic                         busy;
  logic                         skip_pulse;

  modport master (
    input  in_valid, in_data, plane_ready,
    output in_ready, plane_valid, wl_p, wl_n, plane_idx, plane_last, busy, skip_pulse
  );

  modport slave (
    output in_valid, in_data, plane_ready,
    input  in_ready, plane_valid, wl_p, wl_n, plane_idx, plane_last, busy, skip_pulse
  );
endinterface

// File: rtl/bipolar_plane_sequencer.sv
// Converts one vector of signed activations into bipolar positive/negative
// wordline magnitudes and issues them to the CIM array one bit-plane per
// handshake.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : bipolar_plane_sequencer_if.master (input vector handshake,
//          plane handshake with wl_p/wl_n/plane_idx/plane_last, busy, skip_pulse)
// All outputs are registered; next values are computed from the next state.
module bipolar_plane_sequencer #(
  parameter int inBits    = 4,
  parameter int numLanes  = 1,
  parameter int MSB_FIRST = 1,
  parameter int SKIP_ZERO = 1
) (
  input logic                           clk,
  input logic                           rst,
  bipolar_plane_sequencer_if.master     bus
);

  localparam int outBits = inBits - 1;
  localparam int idxBits = (outBits > 1) ? $clog2(outBits) : 1;
  localparam logic [idxBits-1:0] firstIdx = (MSB_FIRST != 0) ? idxBits'(outBits - 1) : '0;
  localparam logic [idxBits-1:0] lastIdx  = (MSB_FIRST != 0) ? '0 : idxBits'(outBits - 1);
  localparam logic [idxBits-1:0] oneIdx   = idxBits'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Returns {p, n}. Negative values use the low outBits of the magnitude, so
  // the most-negative input folds to m=0, giving p=all ones and n=0.
  function automatic logic [2*outBits-1:0] convert_lane(input logic [inBits-1:0] x);
    logic [inBits-1:0]  neg_v;
    logic [outBits-1:0] p_v;
    logic [outBits-1:0] n_v;
    logic [outBits-1:0] m_v;
    neg_v = ~x + {{(inBits-1){1'b0}}, 1'b1};
    m_v   = neg_v[outBits-1:0];
    if (x == '0) begin
      p_v = '0;
      n_v = '0;
    end else if (x[inBits-1] == 1'b0) begin
      p_v = x[outBits-1:0];
      n_v = ~x[outBits-1:0];
    end else begin
      p_v = ~m_v;
      n_v = m_v;
    end
    return {p_v, n_v};
  endfunction

  state_t                             state_r, state_s;
  logic [idxBits-1:0]                 idx_r, idx_s;
  logic [numLanes-1:0][outBits-1:0]   p_r, p_s;
  logic [numLanes-1:0][outBits-1:0]   n_r, n_s;
  logic                               skip_s;
  logic                               in_ready_r, in_ready_s;
  logic                               plane_valid_r, plane_valid_s;
  logic [numLanes-1:0]                wl_p_r, wl_p_s;
  logic [numLanes-1:0]                wl_n_r, wl_n_s;
  logic                               plane_last_r, plane_last_s;
  logic                               busy_r;
  logic                               skip_r;

  // Next-state, held-vector and next-output computation.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    p_s     = p_r;
    n_s     = n_r;
    skip_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          for (int i = 0; i < numLanes; i++) begin
            {p_s[i], n_s[i]} = convert_lane(bus.in_data[i*inBits +: inBits]);
          end
          if ((SKIP_ZERO != 0) && (bus.in_data == '0)) begin
            skip_s = 1'b1;
          end else begin
            state_s = ISSUE;
            idx_s   = firstIdx;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.plane_ready) begin
          if (idx_r == lastIdx) begin
            state_s = IDLE;
          end else if (MSB_FIRST != 0) begin
            idx_s = idx_r - oneIdx;
          end else begin
            idx_s = idx_r + oneIdx;
          end
        end else begin
          state_s = ISSUE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    plane_valid_s = (state_s == ISSUE);
    in_ready_s    = (state_s == IDLE);
    plane_last_s  = plane_valid_s && (idx_s == lastIdx);
    for (int i = 0; i < numLanes; i++) begin
      wl_p_s[i] = plane_valid_s ? p_s[i][idx_s] : 1'b0;
      wl_n_s[i] = plane_valid_s ? n_s[i][idx_s] : 1'b0;
    end
  end

  // State, held vector and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      idx_r         <= '0;
      p_r           <= '0;
      n_r           <= '0;
      in_ready_r    <= 1'b1;
      plane_valid_r <= 1'b0;
      wl_p_r        <= '0;
      wl_n_r        <= '0;
      plane_last_r  <= 1'b0;
      busy_r        <= 1'b0;
      skip_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      p_r           <= p_s;
      n_r           <= n_s;
      in_ready_r    <= in_ready_s;
      plane_valid_r <= plane_valid_s;
      wl_p_r        <= wl_p_s;
      wl_n_r        <= wl_n_s;
      plane_last_r  <= plane_last_s;
      busy_r        <= plane_valid_s;
      skip_r        <= skip_s;
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.plane_valid = plane_valid_r;
  assign bus.wl_p        = wl_p_r;
  assign bus.wl_n        = wl_n_r;
  assign bus.plane_idx   = idx_r;
  assign bus.plane_last  = plane_last_r;
  assign bus.busy        = busy_r;
  assign bus.skip_pulse  = skip_r;

endmodule
